// File: rtl/dup_adder_pkg.sv
// Shared types and helpers for the duplicated-adder sequencing controller.
// Imported by dup_adder_seq_ctrl and parity_tree.
package dup_adder_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        RESP   = 3'd4
    } ctrl_state_t;

    localparam int RETRY_W = 3;
    localparam int CNT_W   = 4;
    localparam int DATA_W  = 64;

    // Callers zero-extend s and one-extend s_inv so unused upper bits agree.
    function automatic logic check_ok(
        input logic [DATA_W-1:0] s,
        input logic [DATA_W-1:0] s_inv,
        input logic              papb,
        input logic              pab
    );
        return (s == ~s_inv) && (papb == pab);
    endfunction

endpackage

// File: rtl/dup_adder_seq_ctrl_parity_tree.sv
// WIDTH-input XOR reduction producing even parity of a data word.
// Used by dup_adder_seq_ctrl for the adder operand parities.
module parity_tree
    import dup_adder_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] data,
    output logic             parity
);

    assign parity = ^data;

endmodule

// File: rtl/dup_adder_seq_ctrl.sv
// Sequencing/check controller for the duplicated carry-select adder.
// Optional DUP_ADDER_FAULT_STATS_EN adds saturating fault/retry counters.
module dup_adder_seq_ctrl
    import dup_adder_pkg::*;
#(
    parameter int WIDTH         = 64,
    parameter int SETTLE_CYCLES = 1,
    parameter int MAX_RETRY     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic               add_pa,
    output logic               add_pb,
    input  logic [WIDTH-1:0]   add_s,
    input  logic [WIDTH-1:0]   add_s_inv,
    input  logic               add_papb,
    input  logic               add_pab,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_sum,
    output logic               rsp_fault,
    output logic [RETRY_W-1:0] rsp_retries,
    output logic               busy
`ifdef DUP_ADDER_FAULT_STATS_EN
    ,
    output logic [15:0]        fault_cnt,
    output logic [15:0]        retry_cnt
`endif
);

    localparam logic [RETRY_W-1:0] MAX_R =
        RETRY_W'(MAX_RETRY);
    localparam logic [CNT_W-1:0] SET_LOAD =
        CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RTY_LOAD =
        CNT_W'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0);

    ctrl_state_t        state;
    logic [CNT_W-1:0]   cnt;
    logic [RETRY_W-1:0] retry_q;
    logic               par_a;
    logic               par_b;
    logic [DATA_W-1:0]  s_ext;
    logic [DATA_W-1:0]  sinv_ext;
    logic               ok;
    logic               in_check;
    logic               retry_go;
    logic               fault_go;

    parity_tree #(.WIDTH(WIDTH)) u_par_a (
        .data   (req_a),
        .parity (par_a)
    );

    parity_tree #(.WIDTH(WIDTH)) u_par_b (
        .data   (req_b),
        .parity (par_b)
    );

    assign s_ext    = DATA_W'(add_s);
    assign sinv_ext = ~DATA_W'(~add_s_inv);
    assign ok       = check_ok(s_ext, sinv_ext, add_papb, add_pab);
    assign in_check = (state == CHECK);
    assign retry_go = in_check && !ok && (retry_q < MAX_R);
    assign fault_go = in_check && !ok && !(retry_q < MAX_R);

    assign req_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign rsp_valid   = (state == RESP);
    assign rsp_retries = retry_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            retry_q   <= '0;
            add_a     <= '0;
            add_b     <= '0;
            add_pa    <= 1'b0;
            add_pb    <= 1'b0;
            rsp_sum   <= '0;
            rsp_fault <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        add_a  <= req_a;
                        add_b  <= req_b;
                        add_pa <= par_a;
                        add_pb <= par_b;
                        state  <= DRIVE;
                    end
                end
                DRIVE: begin
                    // On a retry the inputs never moved, so DRIVE
                    // itself counts as one settle cycle.
                    if (retry_q == '0) begin
                        cnt   <= SET_LOAD;
                        state <= SETTLE;
                    end else if (SETTLE_CYCLES <= 1) begin
                        state <= CHECK;
                    end else begin
                        cnt   <= RTY_LOAD;
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        state <= CHECK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CHECK: begin
                    if (ok) begin
                        rsp_sum   <= add_s;
                        rsp_fault <= 1'b0;
                        state     <= RESP;
                    end else if (retry_go) begin
                        retry_q <= retry_q + 1'b1;
                        state   <= DRIVE;
                    end else begin
                        rsp_sum   <= add_s;
                        rsp_fault <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        retry_q <= '0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DUP_ADDER_FAULT_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fault_cnt <= '0;
            retry_cnt <= '0;
        end else begin
            if (fault_go && (fault_cnt != 16'hFFFF)) begin
                fault_cnt <= fault_cnt + 16'd1;
            end
            if (retry_go && (retry_cnt != 16'hFFFF)) begin
                retry_cnt <= retry_cnt + 16'd1;
            end
        end
    end
`else
    logic unused_fault_go;
    assign unused_fault_go = fault_go;
`endif

endmodule
